// File: rtl/cook_timer.sv
// Countdown cook timer: keypad BCD MM:SS entry, 1 Hz countdown while mag_on, expiry strobe and optional beep.
// Latency: digit entry and clear act on the sampling edge; first decrement TICKS_PER_SEC mag_on cycles after start.
// Backpressure: none; digits arriving while mag_on=1 or with digit>9 are dropped.
//
// Ports:
//   clk, rstn (async active-low), clrn (sync active-low keypad CLEAR)
//   digit_valid/digit : keypad digit strobe and BCD value
//   mag_on            : magnetron running, enables the countdown
//   min_tens..sec_ones: BCD time remaining for the display
//   timer_done        : decode of 0:00; done_pulse: one cycle on expiry; beep: end-of-cook beeper
// Optional feature: define TIMER_BEEP_EN to build the BEEP_CYCLES-long beeper (otherwise beep is tied low).

module cook_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int BEEP_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clrn,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse,
  output logic       beep
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          accept;
  logic          advance;
  logic          sec_tick;
  logic          at_one;
  logic [3:0]    dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;

  assign timer_done = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);

  // Keypad entry is locked out while the magnetron runs, so entry and tick never collide.
  assign accept   = digit_valid && (digit <= 4'd9) && !mag_on;
  assign advance  = mag_on && !timer_done;
  assign sec_tick = advance && (presc == PRESC_MAX);
  assign at_one   = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd1);

  // One-second BCD decrement with borrow chain; only ever used when not at 0:00.
  always_comb begin
    dec_min_tens = min_tens;
    dec_min_ones = min_ones;
    dec_sec_tens = sec_tens;
    dec_sec_ones = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_sec_ones = sec_ones - 4'd1;
    end else if (sec_tens != 4'd0) begin
      dec_sec_ones = 4'd9;
      dec_sec_tens = sec_tens - 4'd1;
    end else if ((min_ones != 4'd0) || (min_tens != 4'd0)) begin
      dec_sec_ones = 4'd9;
      dec_sec_tens = 4'd5;
      if (min_ones != 4'd0) begin
        dec_min_ones = min_ones - 4'd1;
      end else begin
        dec_min_ones = 4'd9;
        dec_min_tens = min_tens - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      presc      <= '0;
      state      <= IDLE;
      done_pulse <= 1'b0;
    end else if (!clrn) begin
      // Clear wins over a coincident tick, so no done_pulse can escape.
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      presc      <= '0;
      state      <= IDLE;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= sec_tick && at_one;

      if (accept) begin
        min_tens <= min_ones;
        min_ones <= sec_tens;
        sec_tens <= sec_ones;
        sec_ones <= digit;
        presc    <= '0;
      end else if (sec_tick) begin
        min_tens <= dec_min_tens;
        min_ones <= dec_min_ones;
        sec_tens <= dec_sec_tens;
        sec_ones <= dec_sec_ones;
        presc    <= '0;
      end else if (advance) begin
        presc <= presc + PW'(1);
      end
      // With mag_on low the prescaler simply holds, keeping the fractional second.

      case (state)
        IDLE: begin
          if (mag_on && !timer_done) state <= RUN;
        end
        RUN: begin
          if (!mag_on)                state <= IDLE;
          else if (sec_tick && at_one) state <= EXPIRED;
        end
        EXPIRED: begin
          if (!mag_on || accept) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TIMER_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  logic [BW-1:0] beep_cnt;

  // Loaded the cycle after done_pulse; beep is high while the count is non-zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beep_cnt <= '0;
    end else if (!clrn || accept) begin
      beep_cnt <= '0;
    end else if (done_pulse) begin
      beep_cnt <= BW'(BEEP_CYCLES);
    end else if (beep_cnt != '0) begin
      beep_cnt <= beep_cnt - BW'(1);
    end
  end

  assign beep = (beep_cnt != '0);
`else
  logic beep_cfg_unused;
  assign beep_cfg_unused = (BEEP_CYCLES < 0);
  assign beep = 1'b0;
`endif

endmodule
